// File: rtl/insn_decode_stage.sv
// insn_decode_stage: registered decode stage between fetch and issue.
// Classifies each accepted instruction (nop/mts/mfs/flow/other), holds it in
// a 2-entry skid buffer, and serialises special-register moves against the
// number of outstanding MTS writes. NOPs can optionally be dropped.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake (in_ready = buffer not full)
//   in_insn, in_pc            instruction word and its address
//   out_valid/out_ready       downstream handshake for the head entry
//   out_insn, out_pc          head entry payload
//   out_class                 one-hot {other, flow, mfs, mts, nop}
//   spr_wr_done               one pulse per completed MTS write
//   flush                     discard buffered and incoming instructions
//   mts_pending, spr_err      outstanding MTS count, sticky underflow flag
//   decoded_cnt, dropped_cnt  output handshakes, dropped NOPs
module insn_decode_stage #(
  parameter int unsigned INSN_W   = 32,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned MAX_MTS  = 2,
  parameter int unsigned NOP_DROP = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        out_class,
  input  logic              spr_wr_done,
  input  logic              flush,
  output logic [3:0]        mts_pending,
  output logic              spr_err,
  output logic [CNT_W-1:0]  decoded_cnt,
  output logic [CNT_W-1:0]  dropped_cnt
);

  localparam int unsigned CLS_W  = 5;
  localparam int unsigned PEND_W = 4;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PC_W-1:0]   pc;
    logic [CLS_W-1:0]  cls;
  } entryT;

  // Entry 0 is always the head; a dequeue shifts entry 1 down.
  entryT              entry0Q, entry1Q, entry0D, entry1D, newEntry;
  logic [1:0]         countQ, countD, afterDeq;
  logic               outValidQ, outValidD;
  logic               inReadyQ, inReadyD;
  logic [CLS_W-1:0]   outClassQ, outClassD;
  logic [PEND_W-1:0]  pendingQ, pendingD;
  logic               sprErrQ, sprErrD;
  logic [CNT_W-1:0]   decodedQ, decodedD, droppedQ, droppedD;
  logic               z9, isNop, isMts, isMfs, isFlow;
  logic [CLS_W-1:0]   clsIn;
  logic               accept, dropNop, enq, deq, mtsHs, headHold;

  // Decode, buffer update and serialisation, all evaluated on next-state
  // values so every output can be registered.
  always_comb begin
    z9     = (in_insn[31:23] == 9'd0);
    isMts  = z9 && (in_insn[7:0] == 8'h0D);
    isMfs  = z9 && (in_insn[7:0] == 8'h0C);
    isNop  = z9 && (in_insn[7:2] == 6'd0) && in_insn[0];
    isFlow = (in_insn[31:27] == 5'b01001);
    clsIn  = 5'b10000;
    if (isMts)       clsIn = 5'b00010;
    else if (isMfs)  clsIn = 5'b00100;
    else if (isNop)  clsIn = 5'b00001;
    else if (isFlow) clsIn = 5'b01000;

    newEntry = '{insn: in_insn, pc: in_pc, cls: clsIn};
    accept   = in_valid && inReadyQ && !flush;
    dropNop  = accept && (NOP_DROP != 0) && isNop;
    enq      = accept && !dropNop;
    deq      = outValidQ && out_ready && !flush;
    mtsHs    = deq && entry0Q.cls[1];

    entry0D  = entry0Q;
    entry1D  = entry1Q;
    afterDeq = countQ - 2'(deq);
    if (deq) entry0D = entry1Q;
    if (enq) begin
      if (afterDeq == 2'd0) entry0D = newEntry;
      else                  entry1D = newEntry;
    end
    countD = flush ? 2'd0 : afterDeq + 2'(enq);

    // A write completing alongside a new MTS handshake nets to zero.
    pendingD = pendingQ;
    if (mtsHs && !spr_wr_done)
      pendingD = pendingQ + 4'd1;
    else if (spr_wr_done && !mtsHs && (pendingQ != 4'd0))
      pendingD = pendingQ - 4'd1;
    sprErrD = sprErrQ || (spr_wr_done && (pendingQ == 4'd0));

    headHold  = (entry0D.cls[1] && (pendingD == PEND_W'(MAX_MTS))) ||
                (entry0D.cls[2] && (pendingD != 4'd0));
    outValidD = (countD != 2'd0) && !headHold;
    inReadyD  = (countD != 2'd2);
    outClassD = (countD != 2'd0) ? entry0D.cls : '0;
    decodedD  = decodedQ + CNT_W'(deq);
    droppedD  = droppedQ + CNT_W'(dropNop);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0Q   <= '0;
      entry1Q   <= '0;
      countQ    <= 2'd0;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      outClassQ <= '0;
      pendingQ  <= '0;
      sprErrQ   <= 1'b0;
      decodedQ  <= '0;
      droppedQ  <= '0;
    end else begin
      entry0Q   <= entry0D;
      entry1Q   <= entry1D;
      countQ    <= countD;
      outValidQ <= outValidD;
      inReadyQ  <= inReadyD;
      outClassQ <= outClassD;
      pendingQ  <= pendingD;
      sprErrQ   <= sprErrD;
      decodedQ  <= decodedD;
      droppedQ  <= droppedD;
    end
  end

  assign in_ready    = inReadyQ;
  assign out_valid   = outValidQ;
  assign out_insn    = entry0Q.insn;
  assign out_pc      = entry0Q.pc;
  assign out_class   = outClassQ;
  assign mts_pending = pendingQ;
  assign spr_err     = sprErrQ;
  assign decoded_cnt = decodedQ;
  assign dropped_cnt = droppedQ;

endmodule
